// File: rtl/sha256_wk_scheduler_pkg.sv
// Shared definitions for the SHA-256 W+K round-word scheduler: round constants,
// scheduler state type and the message-schedule sigma functions.
package sha256_wk_scheduler_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } sched_state_e;

  localparam logic [31:0] K_TABLE [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

endpackage

// File: rtl/sha256_k_rom.sv
// Combinational SHA-256 round-constant lookup, 6-bit round index to 32-bit K.
module sha256_k_rom
  import sha256_wk_scheduler_pkg::*;
(
  input  logic [5:0]  idx_i,
  output logic [31:0] k_o
);

  assign k_o = K_TABLE[idx_i];

endmodule

// File: rtl/sha256_wk_scheduler.sv
// SHA-256 message scheduler emitting W[t]+K[t] per round over a valid/ready stream.
// Optional macro SHA256_WK_OVERLAP_EN allows zero-bubble back-to-back blocks.
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_IDLE | no block held; block_ready high, wk_valid low
// ST_RUN  | block loaded; one registered wk word presented per round
module sha256_wk_scheduler
  import sha256_wk_scheduler_pkg::*;
#(
  parameter int ROUNDS = 64
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         block_valid,
  input  logic [511:0] block_data,
  output logic         block_ready,
  output logic         wk_valid,
  input  logic         wk_ready,
  output logic [31:0]  wk,
  output logic [5:0]   wk_round,
  output logic         wk_last,
  output logic         busy
);

  localparam logic [5:0] LAST_T = 6'(ROUNDS - 1);

  sched_state_e state_q, state_d;
  logic [31:0]  buf_q [16];
  logic [31:0]  buf_d [16];
  logic [5:0]   t_q, t_d;
  logic [31:0]  wk_q, wk_d;
  logic         wk_valid_q, wk_valid_d;
  logic         wk_last_q, wk_last_d;

  logic         wk_fire, last_fire, accept;
  logic [5:0]   t_next, rom_idx;
  logic [3:0]   i_cur, i_m2, i_m7, i_m15;
  logic [31:0]  w_new, w_next, k_val;

  assign wk_fire   = wk_valid_q & wk_ready;
  assign last_fire = wk_fire & wk_last_q;

`ifdef SHA256_WK_OVERLAP_EN
  // Gated with the last handshake so a new block can never displace an unconsumed final word.
  assign block_ready = (state_q == ST_IDLE) | last_fire;
`else
  assign block_ready = (state_q == ST_IDLE);
`endif

  assign accept = block_valid & block_ready;
  assign t_next = t_q + 6'd1;

  // Slot t mod 16 still holds W[t-16] until W[t] overwrites it.
  assign i_cur  = t_next[3:0];
  assign i_m2   = i_cur - 4'd2;
  assign i_m7   = i_cur - 4'd7;
  assign i_m15  = i_cur - 4'd15;
  assign w_new  = sigma1(buf_q[i_m2]) + buf_q[i_m7] + sigma0(buf_q[i_m15]) + buf_q[i_cur];
  assign w_next = (t_next < 6'd16) ? buf_q[i_cur] : w_new;

  assign rom_idx = accept ? 6'd0 : t_next;

  sha256_k_rom u_k_rom (
    .idx_i (rom_idx),
    .k_o   (k_val)
  );

  always_comb begin
    state_d    = state_q;
    t_d        = t_q;
    buf_d      = buf_q;
    wk_d       = wk_q;
    wk_valid_d = wk_valid_q;
    wk_last_d  = wk_last_q;
    if (accept) begin
      for (int i = 0; i < 16; i++) begin
        buf_d[i] = block_data[511 - 32*i -: 32];
      end
      state_d    = ST_RUN;
      t_d        = 6'd0;
      wk_d       = block_data[511:480] + k_val;
      wk_valid_d = 1'b1;
      wk_last_d  = (LAST_T == 6'd0);
    end else if (wk_fire && !wk_last_q) begin
      t_d       = t_next;
      wk_d      = w_next + k_val;
      wk_last_d = (t_next == LAST_T);
      if (t_next >= 6'd16) begin
        buf_d[i_cur] = w_new;
      end
    end else if (last_fire) begin
      state_d    = ST_IDLE;
      wk_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      t_q        <= 6'd0;
      wk_q       <= 32'd0;
      wk_valid_q <= 1'b0;
      wk_last_q  <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        buf_q[i] <= 32'd0;
      end
    end else begin
      state_q    <= state_d;
      t_q        <= t_d;
      wk_q       <= wk_d;
      wk_valid_q <= wk_valid_d;
      wk_last_q  <= wk_last_d;
      buf_q      <= buf_d;
    end
  end

  assign wk_valid = wk_valid_q;
  assign wk       = wk_q;
  assign wk_round = t_q;
  assign wk_last  = wk_last_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sha256_wk_scheduler.sv
// Randomized self-checking bench for sha256_wk_scheduler against a plain-arithmetic
// SHA-256 message-schedule model; covers 64-round and 16-round builds.
module tb_sha256_wk_scheduler;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

`ifdef SHA256_WK_OVERLAP_EN
  localparam int EXP_GAP = 1;
`else
  localparam int EXP_GAP = 2;
`endif

  logic         clk = 1'b0;
  logic         reset_n;
  logic         block_valid, wk_ready, block_ready, wk_valid, wk_last, busy;
  logic [511:0] block_data;
  logic [31:0]  wk;
  logic [5:0]   wk_round;

  logic         b16_valid, r16_ready, b16_ready, v16_valid, l16_last, busy16;
  logic [511:0] b16_data;
  logic [31:0]  wk16;
  logic [5:0]   rnd16;

  int checks = 0;
  int failures = 0;
  logic [31:0]  exp_wk [64];
  logic [511:0] abc_blk, blk_a, blk_b;

  always #5 clk = ~clk;

  sha256_wk_scheduler #(.ROUNDS(64)) u_dut (
    .clk (clk), .reset_n (reset_n),
    .block_valid (block_valid), .block_data (block_data), .block_ready (block_ready),
    .wk_valid (wk_valid), .wk_ready (wk_ready), .wk (wk), .wk_round (wk_round),
    .wk_last (wk_last), .busy (busy)
  );

  sha256_wk_scheduler #(.ROUNDS(16)) u_dut16 (
    .clk (clk), .reset_n (reset_n),
    .block_valid (b16_valid), .block_data (b16_data), .block_ready (b16_ready),
    .wk_valid (v16_valid), .wk_ready (r16_ready), .wk (wk16), .wk_round (rnd16),
    .wk_last (l16_last), .busy (busy16)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  task automatic compute_exp(input logic [511:0] blk);
    logic [31:0] w [64];
    for (int t = 0; t < 64; t++) begin
      if (t < 16) w[t] = blk[511 - 32*t -: 32];
      else w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
      exp_wk[t] = w[t] + KT[t];
    end
  endtask

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[511 - 32*i -: 32] = $urandom;
    return b;
  endfunction

  // Offer a block from a negedge in IDLE; returns at the next negedge with valid dropped.
  task automatic send(input logic [511:0] b);
    block_data  = b;
    block_valid = 1'b1;
    check("bready_idle", 32'(block_ready), 32'd1);
    @(negedge clk);
    block_valid = 1'b0;
  endtask

  // Consume words 0..stop_at-1 against exp_wk; no bubbles allowed once a block is loaded.
  task automatic consume(input int stop_at, input bit rnd, input bit golden);
    int idx = 0;
    int cyc = 0;
    bit stalled = 1'b0;
    bit rdy;
    while (idx < stop_at && cyc < 1000) begin
      if (!wk_valid) begin
        check("bubble", 32'(wk_valid), 32'd1);
      end else begin
        check(stalled ? "stall_wk" : "wk", wk, exp_wk[idx]);
        check(stalled ? "stall_round" : "round", 32'(wk_round), 32'(idx));
        check("last", 32'(wk_last), 32'(idx == 63));
        check("busy_run", 32'(busy), 32'd1);
        if (!wk_last) check("bready_run", 32'(block_ready), 32'd0);
        if (golden && idx == 0)  check("abc_r0", wk, 32'hA3EC9318);
        if (golden && idx == 15) check("abc_r15", wk, 32'hC19BF18C);
        if (golden && idx == 16) check("abc_r16", wk, 32'h45FDCD41);
        rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        wk_ready = rdy;
        stalled = !rdy;
        if (rdy) idx++;
      end
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 1000) check("consume_timeout", 32'(idx), 32'(stop_at));
  endtask

  task automatic post_idle();
    check("post_valid", 32'(wk_valid), 32'd0);
    check("post_busy", 32'(busy), 32'd0);
    check("post_bready", 32'(block_ready), 32'd1);
  endtask

  initial begin
    int gap;
    reset_n = 1'b0;
    block_valid = 1'b0; block_data = '0; wk_ready = 1'b0;
    b16_valid = 1'b0; b16_data = '0; r16_ready = 1'b1;
    abc_blk = '0;
    abc_blk[511:480] = 32'h61626380;
    abc_blk[31:0] = 32'h00000018;

    repeat (3) @(negedge clk);
    check("rst_valid", 32'(wk_valid), 32'd0);
    check("rst_wk", wk, 32'd0);
    check("rst_round", 32'(wk_round), 32'd0);
    check("rst_last", 32'(wk_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    wk_ready = 1'b1;
    @(negedge clk);
    check("rst_bready", 32'(block_ready), 32'd1);
    check("rst_wkrdy_noeffect", 32'(wk_valid), 32'd0);

    compute_exp(abc_blk);
    send(abc_blk);
    consume(64, 1'b0, 1'b1);
    post_idle();

    @(negedge clk);
    send(abc_blk);
    consume(64, 1'b1, 1'b1);
    post_idle();

    for (int n = 0; n < 2; n++) begin
      blk_a = rand_block();
      compute_exp(blk_a);
      @(negedge clk);
      send(blk_a);
      consume(64, 1'b1, 1'b0);
      post_idle();
    end

    compute_exp(abc_blk);
    @(negedge clk);
    send(abc_blk);
    consume(20, 1'b0, 1'b0);
    check("mid_round", 32'(wk_round), 32'd20);
    reset_n = 1'b0;
    #1;
    check("arst_valid", 32'(wk_valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_wk", wk, 32'd0);
    check("arst_round", 32'(wk_round), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("arst_bready", 32'(block_ready), 32'd1);
    send(abc_blk);
    consume(64, 1'b1, 1'b1);
    post_idle();

    blk_b = rand_block();
    @(negedge clk);
    block_data = abc_blk;
    block_valid = 1'b1;
    @(negedge clk);
    block_data = blk_b;
    consume(64, 1'b0, 1'b1);
    gap = 1;
    while (!wk_valid && gap < 10) begin
      @(negedge clk);
      gap++;
    end
    check("b2b_gap", 32'(gap), 32'(EXP_GAP));
    block_valid = 1'b0;
    compute_exp(blk_b);
    consume(64, 1'b0, 1'b0);
    post_idle();

    compute_exp(abc_blk);
    b16_data = abc_blk;
    b16_valid = 1'b1;
    @(negedge clk);
    b16_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check("r16_valid", 32'(v16_valid), 32'd1);
      check("r16_wk", wk16, exp_wk[i]);
      check("r16_round", 32'(rnd16), 32'(i));
      check("r16_last", 32'(l16_last), 32'(i == 15));
      if (i == 15) check("r16_last_wk", wk16, 32'hC19BF18C);
      @(negedge clk);
    end
    check("r16_post_valid", 32'(v16_valid), 32'd0);
    check("r16_post_bready", 32'(b16_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
